tx_dispatch: RTL and testbench

Second-generation transmit dispatcher for the router output stage. Pops flits from the input FIFO and looks up the output port in the routing table. Forwards each flit to one of PORT_COUNT 2-phase tx transceivers. Adds over tx_logic: a wormhole packet mode with per-packet route locking, safe single-pop FIFO sequencing, invalid-port drop, per-port sent counters and a sticky protocol-error flag.

---
 rtl/tx_dispatch_if.sv | 34 +++
 rtl/tx_dispatch.sv | 135 +++++++++++++
 tb/tb_tx_dispatch.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_dispatch_if.sv
// Dispatcher-side bundle: input FIFO, routing table, 2-phase tx ports and status.
interface tx_dispatch_if #(
  parameter int SIZE             = 8,
  parameter int PORT_COUNT       = 5,
  parameter int DESTINATION_BITS = 4,
  parameter int PORT_BITS        = 4,
  parameter int CNT_BITS         = 8
);
  logic                           fifo_read;
  logic                           fifo_empty;
  logic [SIZE-1:0]                fifo_item_out;
  logic [PORT_COUNT-1:0]          fifo_pop_req;
  logic [PORT_COUNT-1:0]          fifo_pop_ack;
  logic [PORT_COUNT*SIZE-1:0]     fifo_pop_data;
  logic [DESTINATION_BITS-1:0]    table_addr;
  logic [PORT_BITS-1:0]           table_data;
  logic [PORT_COUNT-1:0]          port_busy;
  logic                           route_locked;
  logic [PORT_COUNT*CNT_BITS-1:0] sent_count;
  logic [CNT_BITS-1:0]            drop_count;
  logic                           proto_err;

  modport master (
    output fifo_read, fifo_pop_req, fifo_pop_data, table_addr, port_busy,
           route_locked, sent_count, drop_count, proto_err,
    input  fifo_empty, fifo_item_out, fifo_pop_ack, table_data
  );

  modport slave (
    input  fifo_read, fifo_pop_req, fifo_pop_data, table_addr, port_busy,
           route_locked, sent_count, drop_count, proto_err,
    output fifo_empty, fifo_item_out, fifo_pop_ack, table_data
  );
endinterface

// File: rtl/tx_dispatch.sv
// Router output-stage dispatcher: pops flits, routes them to 2-phase tx ports,
// optional wormhole route locking, invalid-port drop and per-port statistics.
//   state | meaning
//   EVAL  | decide on the FIFO head flit (send, drop or wait)
//   POP   | pop pulse issued last edge; let the FIFO head update
module tx_dispatch #(
  parameter int ID               = -1,
  parameter int SIZE             = 8,
  parameter int PORT_COUNT       = 5,
  parameter int DESTINATION_BITS = 4,
  parameter int PORT_BITS        = 4,
  parameter int PACKET_MODE      = 0,
  parameter int CNT_BITS         = 8
) (
  input logic        clk,
  input logic        reset,
  tx_dispatch_if.master bus
);

  // ID only tags simulation debug output of this instance
  if (ID < -1) begin : g_id_tag
  end

  typedef enum logic {EVAL, POP} state_t;

  state_t                state;
  logic                  fifo_read_q;
  logic                  proto_err_q;
  logic [PORT_COUNT-1:0] ack_old;
  logic [PORT_COUNT-1:0] ack_rx;
  logic [PORT_COUNT-1:0] pop_req;
  logic [PORT_COUNT-1:0] busy;
  logic [PORT_COUNT-1:0] tgt_hot;
  logic [SIZE-1:0]       pop_data [PORT_COUNT];
  logic [CNT_BITS-1:0]   sent_cnt [PORT_COUNT];
  logic [CNT_BITS-1:0]   drop_cnt;
  logic [PORT_BITS-1:0]  lock_port;
  logic [PORT_BITS-1:0]  tgt;
  logic                  locked;
  logic                  lock_drop;
  logic                  tgt_valid;
  logic                  tail;
  logic                  send;
  logic                  drop;
  logic [SIZE-1:0]       flit;

  assign flit           = bus.fifo_item_out;
  assign tail           = (PACKET_MODE != 0) && flit[SIZE-1];
  assign ack_rx         = bus.fifo_pop_ack ^ ack_old;
  assign bus.table_addr = flit[DESTINATION_BITS-1:0];

  // A held wormhole route overrides the table; a DROP route is never valid
  always_comb begin
    tgt       = bus.table_data;
    tgt_valid = int'(bus.table_data) < PORT_COUNT;
    if (locked) begin
      tgt       = lock_port;
      tgt_valid = !lock_drop;
    end
    tgt_hot = '0;
    for (int k = 0; k < PORT_COUNT; k++)
      tgt_hot[k] = tgt_valid && (int'(tgt) == k);
  end

  assign send = (state == EVAL) && !bus.fifo_empty && tgt_valid && |(tgt_hot & ~busy);
  assign drop = (state == EVAL) && !bus.fifo_empty && !tgt_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= EVAL;
      fifo_read_q <= 1'b0;
      proto_err_q <= 1'b0;
      ack_old     <= '0;
      pop_req     <= '0;
      busy        <= '0;
      locked      <= 1'b0;
      lock_drop   <= 1'b0;
      lock_port   <= '0;
      drop_cnt    <= '0;
      for (int k = 0; k < PORT_COUNT; k++) begin
        pop_data[k] <= '0;
        sent_cnt[k] <= '0;
      end
    end else begin
      ack_old     <= bus.fifo_pop_ack;
      fifo_read_q <= 1'b0;
      if (|(ack_rx & ~busy))
        proto_err_q <= 1'b1;
      busy <= (busy & ~ack_rx) | (send ? tgt_hot : '0);

      case (state)
        EVAL: begin
          if (send || drop) begin
            fifo_read_q <= 1'b1;
            state       <= POP;
            if (drop)
              drop_cnt <= drop_cnt + CNT_BITS'(1);
            if (PACKET_MODE != 0) begin
              if (locked) begin
                if (tail)
                  locked <= 1'b0;
              end else if (!tail) begin
                locked    <= 1'b1;
                lock_port <= tgt;
                lock_drop <= drop;
              end
            end
          end
        end
        POP: state <= EVAL;
      endcase

      for (int k = 0; k < PORT_COUNT; k++) begin
        if (send && tgt_hot[k]) begin
          pop_req[k]  <= ~pop_req[k];
          pop_data[k] <= flit;
          sent_cnt[k] <= sent_cnt[k] + CNT_BITS'(1);
        end
      end
    end
  end

  assign bus.fifo_read    = fifo_read_q;
  assign bus.fifo_pop_req = pop_req;
  assign bus.port_busy    = busy;
  assign bus.route_locked = locked;
  assign bus.drop_count   = drop_cnt;
  assign bus.proto_err    = proto_err_q;

  for (genvar k = 0; k < PORT_COUNT; k++) begin : g_pack
    assign bus.fifo_pop_data[SIZE*k +: SIZE]      = pop_data[k];
    assign bus.sent_count[CNT_BITS*k +: CNT_BITS] = sent_cnt[k];
  end

endmodule

// File: tb/tb_tx_dispatch.sv
// Directed bench for tx_dispatch: one flit-per-flit instance and one wormhole
// instance, with FIFO/table models and a send scoreboard per instance.
module tb_tx_dispatch;

  localparam int SIZE = 8;
  localparam int PC   = 5;
  localparam int DB   = 4;
  localparam int PB   = 4;
  localparam int CB   = 8;

  typedef struct packed {
    logic [3:0] port;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic reset;

  tx_dispatch_if #(.SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB), .PORT_BITS(PB), .CNT_BITS(CB)) bus0 ();
  tx_dispatch_if #(.SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB), .PORT_BITS(PB), .CNT_BITS(CB)) bus1 ();

  tx_dispatch #(.ID(0), .SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB), .PORT_BITS(PB),
                .PACKET_MODE(0), .CNT_BITS(CB)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  tx_dispatch #(.ID(1), .SIZE(SIZE), .PORT_COUNT(PC), .DESTINATION_BITS(DB), .PORT_BITS(PB),
                .PACKET_MODE(1), .CNT_BITS(CB)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  fq0[$], fq1[$];
  exp_t        sb0[$], sb1[$];
  logic [PB-1:0] tbl0 [16];
  logic [PB-1:0] tbl1 [16];
  logic [PC-1:0] req_prev0, req_prev1;
  logic        rd_prev0, rd_prev1;
  bit          auto0, auto1;
  int          rd_cnt0;
  int          last_send0 [PC];

  assign bus0.table_data = tbl0[bus0.table_addr];
  assign bus1.table_data = tbl1[bus1.table_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    bus0.fifo_empty    = (fq0.size() == 0);
    bus0.fifo_item_out = (fq0.size() != 0) ? fq0[0] : 8'h00;
    bus1.fifo_empty    = (fq1.size() == 0);
    bus1.fifo_item_out = (fq1.size() != 0) ? fq1[0] : 8'h00;
  endtask

  // port < 0 means the flit is expected to be dropped
  task automatic push(input int d, input logic [7:0] f, input int port);
    exp_t e;
    e.port = 4'(port);
    e.data = f;
    if (d == 0) begin
      fq0.push_back(f);
      if (port >= 0) sb0.push_back(e);
    end else begin
      fq1.push_back(f);
      if (port >= 0) sb1.push_back(e);
    end
    refresh();
  endtask

  task automatic drain(input int d, input int budget);
    int n = 0;
    while (n < budget && ((d == 0) ? (fq0.size() + sb0.size()) : (fq1.size() + sb1.size())) != 0) begin
      @(negedge clk);
      n++;
    end
    check((d == 0) ? "drain0" : "drain1", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  // FIFO pop, fifo_read spacing, send scoreboard and optional auto-ack, instance 0
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      req_prev0 = bus0.fifo_pop_req;
      rd_prev0  = 1'b0;
    end else begin
      if (bus0.fifo_read) begin
        check("rd_gap0", rd_prev0, 0);
        rd_cnt0++;
        if (fq0.size() != 0) void'(fq0.pop_front());
        refresh();
      end
      rd_prev0 = bus0.fifo_read;
      for (int k = 0; k < PC; k++) begin
        if (bus0.fifo_pop_req[k] != req_prev0[k]) begin
          last_send0[k] = cyc;
          if (sb0.size() == 0) check("unexpected_send0", sb0.size(), 1);
          else begin
            e = sb0.pop_front();
            check("send0_port", k, e.port);
            check("send0_data", bus0.fifo_pop_data[k*SIZE +: SIZE], e.data);
          end
        end
      end
      req_prev0 = bus0.fifo_pop_req;
      if (auto0) bus0.fifo_pop_ack = bus0.fifo_pop_req;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      req_prev1 = bus1.fifo_pop_req;
      rd_prev1  = 1'b0;
    end else begin
      if (bus1.fifo_read) begin
        check("rd_gap1", rd_prev1, 0);
        if (fq1.size() != 0) void'(fq1.pop_front());
        refresh();
      end
      rd_prev1 = bus1.fifo_read;
      for (int k = 0; k < PC; k++) begin
        if (bus1.fifo_pop_req[k] != req_prev1[k]) begin
          if (sb1.size() == 0) check("unexpected_send1", sb1.size(), 1);
          else begin
            e = sb1.pop_front();
            check("send1_port", k, e.port);
            check("send1_data", bus1.fifo_pop_data[k*SIZE +: SIZE], e.data);
          end
        end
      end
      req_prev1 = bus1.fifo_pop_req;
      if (auto1) bus1.fifo_pop_ack = bus1.fifo_pop_req;
    end
  end

  initial begin
    int base;
    int c;
    reset = 1'b1;
    auto0 = 1'b0;
    auto1 = 1'b0;
    rd_cnt0 = 0;
    for (int i = 0; i < PC; i++) last_send0[i] = 0;
    for (int i = 0; i < 16; i++) begin
      tbl0[i] = '0;
      tbl1[i] = '0;
    end
    bus0.fifo_pop_ack = '0;
    bus1.fifo_pop_ack = '0;
    refresh();
    repeat (3) @(negedge clk);

    // reset state
    check("rst_fifo_read", bus0.fifo_read, 0);
    check("rst_req", bus0.fifo_pop_req, 0);
    check("rst_busy", bus0.port_busy, 0);
    check("rst_sent", bus0.sent_count, 0);
    check("rst_data", bus0.fifo_pop_data, 0);
    check("rst_drop", bus0.drop_count, 0);
    check("rst_perr", bus0.proto_err, 0);
    check("rst_locked1", bus1.route_locked, 0);
    reset = 1'b0;
    @(negedge clk);

    // two flits to ports 1 and 2, two cycles apart
    tbl0[3] = 4'd1;
    tbl0[1] = 4'd2;
    auto0 = 1'b1;
    base = rd_cnt0;
    push(0, 8'h13, 1);
    push(0, 8'h21, 2);
    drain(0, 40);
    check("t1_spacing", last_send0[2] - last_send0[1], 2);
    check("t1_reads", rd_cnt0 - base, 2);
    check("t1_sent1", bus0.sent_count[1*CB +: CB], 1);
    check("t1_sent2", bus0.sent_count[2*CB +: CB], 1);
    check("t1_busy", bus0.port_busy, 0);
    check("t1_locked", bus0.route_locked, 0);

    // back-pressure: second flit to port 1 waits for the ack
    auto0 = 1'b0;
    tbl0[5] = 4'd1;
    base = rd_cnt0;
    push(0, 8'h15, 1);
    push(0, 8'h25, 1);
    repeat (8) @(negedge clk);
    check("t2_pending", sb0.size(), 1);
    check("t2_head", bus0.fifo_item_out, 8'h25);
    check("t2_reads", rd_cnt0 - base, 1);
    check("t2_busy1", bus0.port_busy[1], 1);
    c = cyc;
    bus0.fifo_pop_ack[1] = ~bus0.fifo_pop_ack[1];
    drain(0, 40);
    check("t2_latency", last_send0[1], c + 2);
    bus0.fifo_pop_ack[1] = ~bus0.fifo_pop_ack[1];
    repeat (2) @(negedge clk);
    check("t2_busy_clr", bus0.port_busy, 0);

    // invalid port: popped and dropped
    tbl0[7] = 4'd7;
    base = rd_cnt0;
    push(0, 8'h17, -1);
    drain(0, 40);
    check("t3_drop", bus0.drop_count, 1);
    check("t3_read", rd_cnt0 - base, 1);
    check("t3_sent1", bus0.sent_count[1*CB +: CB], 3);

    // ack on idle port 4 is a sticky protocol error
    check("t5_perr0", bus0.proto_err, 0);
    bus0.fifo_pop_ack[4] = ~bus0.fifo_pop_ack[4];
    repeat (2) @(negedge clk);
    check("t5_perr1", bus0.proto_err, 1);
    auto0 = 1'b1;
    push(0, 8'h13, 1);
    drain(0, 40);
    check("t5_perr_hold", bus0.proto_err, 1);

    // wormhole: route held on port 0 across a table change
    auto1 = 1'b1;
    push(1, 8'h02, 0);
    drain(1, 40);
    check("t4_lock_head", bus1.route_locked, 1);
    tbl1[2] = 4'd3;
    tbl1[5] = 4'd3;
    push(1, 8'h55, 0);
    drain(1, 40);
    check("t4_lock_body", bus1.route_locked, 1);
    push(1, 8'hA5, 0);
    drain(1, 40);
    check("t4_unlock", bus1.route_locked, 0);
    check("t4_sent0", bus1.sent_count[0*CB +: CB], 3);
    check("t4_sent3", bus1.sent_count[3*CB +: CB], 0);

    // invalid head locks a DROP route through the tail
    tbl1[9] = 4'd7;
    push(1, 8'h09, -1);
    push(1, 8'h02, -1);
    push(1, 8'h81, -1);
    drain(1, 60);
    check("t4_drop3", bus1.drop_count, 3);
    check("t4_drop_unlock", bus1.route_locked, 0);
    push(1, 8'h82, 3);
    drain(1, 40);
    check("t4_single_nolock", bus1.route_locked, 0);
    check("t4_single_sent3", bus1.sent_count[3*CB +: CB], 1);

    // async reset while port 2 has a request outstanding
    auto0 = 1'b0;
    push(0, 8'h21, 2);
    drain(0, 40);
    check("t6_busy2", bus0.port_busy[2], 1);
    #2 reset = 1'b1;
    #1;
    check("t6_req", bus0.fifo_pop_req, 0);
    check("t6_busy", bus0.port_busy, 0);
    check("t6_sent", bus0.sent_count, 0);
    check("t6_data", bus0.fifo_pop_data, 0);
    check("t6_drop", bus0.drop_count, 0);
    check("t6_perr", bus0.proto_err, 0);
    check("t6_read", bus0.fifo_read, 0);
    bus0.fifo_pop_ack = '0;
    bus1.fifo_pop_ack = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // counter wrap at 256 sends on port 1
    auto0 = 1'b1;
    for (int i = 0; i < 255; i++) push(0, {4'(i), 4'h3}, 1);
    drain(0, 1500);
    check("t6_cnt255", bus0.sent_count[1*CB +: CB], 8'hFF);
    push(0, 8'h33, 1);
    drain(0, 40);
    check("t6_wrap", bus0.sent_count[1*CB +: CB], 0);
    check("t6_perr_after", bus0.proto_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
